// File: rtl/prog_loader_pkg.sv
// Shared state encoding and framing constants for the boot program loader.
package prog_loader_pkg;

    localparam logic [2:0] HDR_HI  = 3'd0;
    localparam logic [2:0] HDR_LO  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] CHECK   = 3'd4;
    localparam logic [2:0] RUN     = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader is willing to take a byte.
    function automatic logic rx_open(input logic [2:0] st);
        return (st == HDR_HI) || (st == HDR_LO) || (st == PAYLOAD) || (st == CHECK);
    endfunction

    function automatic logic last_byte(input logic [1:0] cnt);
        return cnt == 2'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
    parameter int ADDR_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_wr_addr;
    logic [31:0]       imem_wr_data;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Shifts bytes MSB-first into a 32-bit word; word_full marks a completed word until the next shift.
module prog_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        shift,
    input  logic        clear,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt,
    output logic        word_full
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word      <= '0;
            byte_cnt  <= '0;
            word_full <= 1'b0;
        end else if (clear) begin
            word      <= '0;
            byte_cnt  <= '0;
            word_full <= 1'b0;
        end else if (shift) begin
            word      <= {word[23:0], din};
            byte_cnt  <= byte_cnt + 2'd1;
            word_full <= (byte_cnt == 2'd3);
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: turns a big-endian byte image into imem writes and holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_WORDS      = 256,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1000000
)(
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    input  logic         reload,
    output logic         cpu_rst,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [15:0]  words_loaded
);
    logic [2:0]        state;
    logic [15:0]       n_words;
    logic [15:0]       idx;
    logic [31:0]       tcnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [31:0]       data_hold;
    logic [31:0]       word;
    logic [1:0]        byte_cnt;
    logic              word_full;
    logic              xfer;
    logic              in_write;
    logic              cnt_en;
    logic              tmo;
    logic [15:0]       hdr_n;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign bus.rx_ready = rx_open(state);
    assign xfer         = bus.rx_valid & bus.rx_ready;
    assign in_write     = (state == WRITE);
    assign cnt_en       = (state == HDR_LO) || (state == PAYLOAD) || (state == CHECK);
    assign tmo          = (TIMEOUT_CYCLES != 0) && cnt_en && !xfer
                          && (tcnt == 32'(TIMEOUT_CYCLES - 1));
    assign hdr_n        = {n_words[15:8], bus.rx_data};

    prog_loader_word_assembler u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .din       (bus.rx_data),
        .shift     (xfer && (state == PAYLOAD) && !reload),
        .clear     (reload),
        .word      (word),
        .byte_cnt  (byte_cnt),
        .word_full (word_full)
    );

    // Write port is live only in WRITE; address/data hold their last written values otherwise.
    assign bus.imem_wr_en   = in_write & word_full & ~reload;
    assign bus.imem_wr_addr = in_write ? ADDR_W'({idx, 2'b00}) : addr_hold;
    assign bus.imem_wr_data = in_write ? word : data_hold;

    assign cpu_rst      = (state != RUN);
    assign busy         = (state != RUN) && (state != ERR);
    assign done         = (state == RUN);
    assign error        = (state == ERR);
    assign words_loaded = idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HDR_HI;
            n_words   <= '0;
            idx       <= '0;
            tcnt      <= '0;
            addr_hold <= '0;
            data_hold <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else if (reload) begin
            state <= HDR_HI;
            idx   <= '0;
            tcnt  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            tcnt <= (cnt_en && !xfer) ? tcnt + 32'd1 : 32'd0;
            case (state)
                HDR_HI: begin
                    if (xfer) begin
                        n_words[15:8] <= bus.rx_data;
                        state         <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        n_words[7:0] <= bus.rx_data;
                        if (hdr_n == 16'd0 || {16'd0, hdr_n} > 32'(MAX_WORDS))
                            state <= ERR;
                        else
                            state <= PAYLOAD;
                    end else if (tmo) begin
                        state <= ERR;
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.rx_data;
`endif
                        if (last_byte(byte_cnt))
                            state <= WRITE;
                    end else if (tmo) begin
                        state <= ERR;
                    end
                end
                WRITE: begin
                    addr_hold <= ADDR_W'({idx, 2'b00});
                    data_hold <= word;
                    idx       <= idx + 16'd1;
                    if (idx == n_words - 16'd1)
`ifdef PROG_LOADER_CHECKSUM_EN
                        state <= CHECK;
`else
                        state <= RUN;
`endif
                    else
                        state <= PAYLOAD;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer)
                        state <= (bus.rx_data == csum) ? RUN : ERR;
                    else if (tmo)
                        state <= ERR;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: header table, directed corner sequences, random images vs a byte-level model.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int MAXW = 256;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reload = 1'b0;
    logic        cpu_rst, busy, done, error;
    logic [15:0] words_loaded;

    prog_loader_if #(.ADDR_W(32)) bus();

    prog_loader #(.MAX_WORDS(MAXW), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .reload       (reload),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t        wq[$];
    wr_t        exp_q[$];
    logic [7:0] img[$];
    logic       xfer_seen = 1'b0;

    typedef struct { logic [15:0] n; logic exp_err; logic exp_busy; } hdr_vec_t;
    hdr_vec_t hv[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) xfer_seen = bus.rx_valid & bus.rx_ready;

    // Every write must follow a transfer edge directly, and rx_ready drops only for writes.
    always @(negedge clk) begin
        if (bus.imem_wr_en) begin
            wq.push_back({bus.imem_wr_addr, bus.imem_wr_data});
            check("wr_latency", 64'(xfer_seen), 64'd1);
            check("ready_in_write", 64'(bus.rx_ready), 64'd0);
        end else if (busy && !reload) begin
            check("ready_outside_write", 64'(bus.rx_ready), 64'd1);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        for (int g = 0; g < gap; g++) begin
            bus.rx_valid = 1'b0;
            step();
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: rx_ready stayed %0b, required 1 within 50 cycles", bus.rx_ready);
        end
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic add_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = HDR_BYTES; i < img.size(); i++) x ^= img[i];
        img.push_back(x);
`endif
    endtask

    // Reference: header gives N, then N big-endian words at byte addresses 4*i, then optional XOR byte.
    function automatic bit build_expect();
        int n;
        exp_q.delete();
        n = int'({img[0], img[1]});
        if (n == 0 || n > MAXW) return 1'b0;
        for (int i = 0; i < n; i++) begin
            int a = HDR_BYTES + 4 * i;
            exp_q.push_back({32'(i * 4), img[a], img[a+1], img[a+2], img[a+3]});
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = HDR_BYTES; i < HDR_BYTES + 4 * n; i++) x ^= img[i];
            return img[HDR_BYTES + 4 * n] == x;
        end
`else
        return 1'b1;
`endif
    endfunction

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
        check("reload_clears", {done, error, busy, words_loaded}, {1'b0, 1'b0, 1'b1, 16'd0});
    endtask

    task automatic run_image(input string tag, input int gap_mode, input bit do_reload);
        bit ok;
        int n;
        int g;
        if (do_reload) pulse_reload();
        wq.delete();
        for (int i = 0; i < img.size(); i++) begin
            g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
            send_byte(img[i], g);
        end
        step();
        step();
        ok = build_expect();
        n  = int'({img[0], img[1]});
        check({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_write"}, (i < wq.size()) ? wq[i] : ~exp_q[i], exp_q[i]);
        check({tag, "_done"}, 64'(done), 64'(ok));
        check({tag, "_error"}, 64'(error), 64'(!ok));
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!ok));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), (n == 0 || n > MAXW) ? 64'd0 : 64'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        hv[0] = '{16'h0000, 1'b1, 1'b0};
        hv[1] = '{16'h0101, 1'b1, 1'b0};
        hv[2] = '{16'hFFFF, 1'b1, 1'b0};
        hv[3] = '{16'h0200, 1'b1, 1'b0};
        hv[4] = '{16'h0100, 1'b0, 1'b1};
        hv[5] = '{16'h0001, 1'b0, 1'b1};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        step();
        step();
        check("rst_status", {cpu_rst, busy, done, error}, 4'b1100);
        check("rst_wr", {bus.imem_wr_en, bus.imem_wr_addr, bus.imem_wr_data}, 65'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        check("rst_ready", 64'(bus.rx_ready), 64'd1);
        rst = 1'b1;
        step();

        // Basic load, rx_valid held high.
        img = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h05, 8'h00, 8'h42, 8'h10, 8'h20};
        add_csum();
        run_image("basic", 0, 1'b0);
        check("basic_w0", (wq.size() > 0) ? wq[0] : 64'd0, {32'h0, 32'h20020005});
        check("basic_w1", (wq.size() > 1) ? wq[1] : 64'd0, {32'h4, 32'h00421020});
        check("basic_hold", {bus.imem_wr_addr, bus.imem_wr_data}, {32'h4, 32'h00421020});

        // Same image with rx_valid gaps every other cycle.
        run_image("gaps", 1, 1'b1);

        // Reload after a successful run, then a one-word image.
        img = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        add_csum();
        run_image("reload", 0, 1'b1);
        check("reload_w0", (wq.size() > 0) ? wq[0] : 64'd0, {32'h0, 32'hAABBCCDD});

        // Header table.
        for (int v = 0; v < 6; v++) begin
            pulse_reload();
            wq.delete();
            send_byte(hv[v].n[15:8], 0);
            send_byte(hv[v].n[7:0], 0);
            step();
            check("hdr_error", 64'(error), 64'(hv[v].exp_err));
            check("hdr_busy", 64'(busy), 64'(hv[v].exp_busy));
            check("hdr_cpu_rst", 64'(cpu_rst), 64'd1);
            check("hdr_nwrites", 64'(wq.size()), 64'd0);
        end

        // Timeout: stall mid-word.
        pulse_reload();
        wq.delete();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        for (int i = 1; i <= TMO; i++) begin
            step();
            check("timeout_err", 64'(error), 64'(i == TMO));
        end
        check("timeout_nwrites", 64'(wq.size()), 64'd0);
        check("timeout_cpu_rst", 64'(cpu_rst), 64'd1);

        // Reload arriving in the WRITE cycle suppresses the write.
        pulse_reload();
        wq.delete();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        bus.rx_data  = 8'h44;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        reload = 1'b1;
        #1;
        check("rld_wr_suppress", 64'(bus.imem_wr_en), 64'd0);
        step();
        reload = 1'b0;
        check("rld_wr_after", {cpu_rst, busy, done, error, words_loaded}, {4'b1100, 16'd0});
        check("rld_wr_nwrites", 64'(wq.size()), 64'd0);

        // Asynchronous reset in the middle of the second word.
        pulse_reload();
        wq.delete();
        img = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        for (int i = 0; i < img.size(); i++) send_byte(img[i], 0);
        rst = 1'b0;
        #1;
        check("arst_status", {cpu_rst, busy, done, error}, 4'b1100);
        check("arst_words", 64'(words_loaded), 64'd0);
        check("arst_nwrites", 64'(wq.size()), 64'd1);
        step();
        rst = 1'b1;
        step();

`ifdef PROG_LOADER_CHECKSUM_EN
        img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        run_image("csum_good", 0, 1'b1);
        check("csum_good_done", 64'(done), 64'd1);
        img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        run_image("csum_bad", 0, 1'b1);
        check("csum_bad_error", {error, cpu_rst}, 2'b11);
`endif

        // Random images with random gaps.
        for (int r = 0; r < 8; r++) begin
            int n = int'($urandom_range(1, 8));
            img.delete();
            img.push_back(8'(n >> 8));
            img.push_back(8'(n));
            for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
            add_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
            if (r % 3 == 2) img[img.size() - 1] = img[img.size() - 1] ^ 8'hA5;
`endif
            run_image("random", 2, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the pipelined CPU.
- Accepts a byte stream (header + instruction words) and writes each assembled 32-bit word into the instruction memory write port.
- Holds the CPU in reset (drives the CPU's global reset) until a complete, valid image is loaded, then releases it.
- Can re-enter load mode on request without a chip reset.

Parameters:
- MAX_WORDS, 256, instruction-memory capacity in words; header counts above this are rejected.
- ADDR_W, 32, width of the instruction-memory write address (byte address, same space as PC).
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes mid-image before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid & rx_ready are both high on a rising edge.
- reload  in  1  single-cycle request to start a new load.
- imem_wr_en  out  1  one-cycle instruction-memory write strobe.
- imem_wr_addr  out  ADDR_W  byte address = word_index*4.
- imem_wr_data  out  32  assembled instruction word.
- cpu_rst  out  1  active-high hold to the CPU reset input.
- busy  out  1  load in progress.
- done  out  1  image loaded, CPU running.
- error  out  1  load aborted.
- words_loaded  out  16  words written in the current or last load.

Behaviour:
- Reset (rst low, asynchronous):
  - state = HDR_HI; cpu_rst=1; busy=1; done=0; error=0.
  - imem_wr_en=0; imem_wr_addr=0; imem_wr_data=0; words_loaded=0.
  - byte_cnt=0; timeout counter=0.
- Image format, all fields big-endian:
  - 16-bit word count N (high byte first).
  - N×4 payload bytes; within each word the first byte is bits [31:24].
  - Followed by the checksum byte only when CHECKSUM_EN is defined.
- States:
  - HDR_HI: rx_ready=1. On transfer, latch N[15:8] → HDR_LO.
  - HDR_LO: rx_ready=1. On transfer, latch N[7:0]. N==0 or N>MAX_WORDS → ERR; otherwise → PAYLOAD.
  - PAYLOAD: rx_ready=1. Each transfer shifts the byte into the word register and increments byte_cnt (2-bit, wraps). The 4th byte → WRITE.
  - WRITE: rx_ready=0. imem_wr_en=1 for exactly this cycle, with addr=idx*4 and data=the assembled word. Write latency is the cycle after the 4th byte transfers. Then idx and words_loaded increment. If idx==N-1: → CHECK if CHECKSUM_EN, else RUN. Otherwise → PAYLOAD.
  - CHECK: described under Optional Feature.
  - RUN: rx_ready=0; cpu_rst=0; busy=0; done=1. CPU comes out of reset on the first cycle in RUN.
  - ERR: rx_ready=0; cpu_rst=1; busy=0; error=1. The state is sticky.
- reload:
  - Sampled in any state, and takes priority over all other transitions that cycle.
  - Next state is HDR_HI, with cpu_rst=1 on the very next edge.
  - Clears idx, words_loaded, byte_cnt, error and done.
  - imem_wr_en is suppressed in that cycle, even in WRITE.
- Timeout:
  - Counter increments each cycle in HDR_LO, PAYLOAD or CHECK with no transfer; it resets on every transfer.
  - Reaching TIMEOUT_CYCLES → ERR. HDR_HI never times out.
- rx_ready is a registered-state decode only (no combinational path from rx_valid). rx_valid while rx_ready=0 is ignored and the byte is not consumed.
- imem_wr_addr/imem_wr_data hold their last values outside WRITE.
- Asynchronous reset mid-load aborts immediately. The partially written instruction memory is not cleared.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes (header excluded) is kept.
  - After the last WRITE → CHECK, with rx_ready=1.
  - On transfer: byte == XOR → RUN; mismatch → ERR.
  - The XOR register clears on reset and on reload.
- Undefined: no CHECK state and no XOR logic; the last WRITE → RUN directly.

Decomposition:
- Package prog_loader_pkg:
  - State encoding localparams: HDR_HI, HDR_LO, PAYLOAD, WRITE, CHECK, RUN, ERR (3-bit).
  - HDR_BYTES=2, BYTES_PER_WORD=4.
- One sub-module: word_assembler.
  - Inputs: byte, shift strobe, clear.
  - Outputs: 32-bit shift register, 2-bit byte counter, word_full flag.
  - Clocked by clk/rst.
- The FSM, index, timeout and checksum stay in prog_loader.

Test Plan:
- Basic load: bytes 00 02 | 20 02 00 05 | 00 42 10 20, rx_valid held high.
  - imem writes (0x0, 0x20020005) then (0x4, 0x00421020), each one cycle after the 4th byte.
  - Then done=1, cpu_rst=0, words_loaded=2.
- Backpressure/gaps: same image with rx_valid toggling every other cycle, plus rx_valid=1 during WRITE.
  - Identical writes; no byte dropped or duplicated.
  - rx_ready=0 exactly in WRITE cycles.
- Bad header: N=0x0000, and separately N=MAX_WORDS+1 (0x0101).
  - ERR, error=1, cpu_rst stays 1, zero writes.
- Reload mid-run: after a successful load, pulse reload, then send a 1-word image 00 01 AA BB CC DD.
  - cpu_rst=1 next cycle; single write (0x0, 0xAABBCCDD); done=1.
- Timeout: with TIMEOUT_CYCLES=16, send 00 01 AA then stall.
  - ERR on the 16th idle cycle; no write occurs.
- With PROG_LOADER_CHECKSUM_EN: image 00 01 11 22 33 44.
  - Checksum 0x44 → RUN.
  - Checksum 0x00 → ERR, error=1, cpu_rst=1.
